bky_chain_loader: RTL and testbench

- Clocked, fabric-side controller for the Buckeye amplifier serial configuration chains. It is an alternative to the JTAG pass-through path.
- Serializes one NBITS-wide pattern onto the DSND/BCLK lines of the selected amplifiers, all in parallel.
- At the same time it deserializes each selected chip's DRTN stream into a per-chip readback register. The readback holds the chip's previous contents.
- Sits between the slow-control register file (which supplies PATTERN and MASK and reads RD_DATA) and the amplifier pins, behind the DSND/BCLK output mux.

---
 rtl/bky_pkg.sv | 25 ++
 rtl/bky_chain_loader_if.sv | 35 +++
 rtl/bky_rb_shreg.sv | 31 +++
 rtl/bky_chain_loader.sv | 170 +++++++++++++++++
 tb/tb_bky_chain_loader.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bky_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bky_pkg : shared constants, state encoding and mask helper for the       |
// |           Buckeye chain loader.                              Rev 1.0     |
// +--------------------------------------------------------------------------+
package bky_pkg;

  localparam int BKY_NCHIP    = 6;
  localparam int BKY_NBITS    = 48;
  localparam int BKY_HALF_PER = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    DONE  = 2'd3
  } bky_state_t;

  // An empty selection means "load every amplifier".
  function automatic logic [BKY_NCHIP-1:0] bky_eff_mask(input logic [BKY_NCHIP-1:0] mask);
    return (mask == '0) ? '1 : mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bky_chain_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bky_chain_loader_if : register-file and amplifier-pin bundle of the      |
// |                       chain loader.                          Rev 1.0     |
// +--------------------------------------------------------------------------+
interface bky_chain_loader_if
  import bky_pkg::*;
#(
  parameter int NBITS = BKY_NBITS
);

  logic                 start;
  logic [BKY_NCHIP:1]   mask;
  logic [NBITS-1:0]     pattern;
  logic                 busy;
  logic                 done;
  logic [BKY_NCHIP:1]   dsnd;
  logic [BKY_NCHIP:1]   bclk;
  logic [BKY_NCHIP:1]   drtn;
  logic [2:0]           rd_sel;
  logic [NBITS-1:0]     rd_data;
  logic [BKY_NCHIP:1]   mismatch;

  modport slave (
    input  start, mask, pattern, drtn, rd_sel,
    output busy, done, dsnd, bclk, rd_data, mismatch
  );

  modport master (
    output start, mask, pattern, drtn, rd_sel,
    input  busy, done, dsnd, bclk, rd_data, mismatch
  );

endinterface
`default_nettype wire

// File: rtl/bky_rb_shreg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bky_rb_shreg : per-chip readback shift register, captures into the LSB.  |
// |                                                              Rev 1.0     |
// +--------------------------------------------------------------------------+
module bky_rb_shreg
  import bky_pkg::*;
#(
  parameter int NBITS = BKY_NBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_din,
  output logic [NBITS-1:0] o_q
);

  logic [NBITS-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= {r_q[NBITS-2:0], i_din};
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/bky_chain_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bky_chain_loader : shifts one pattern into the selected Buckeye chains   |
// |   and captures each chip's previous contents. Option: BKY_VERIFY_EN.     |
// |                                                              Rev 1.0     |
// +--------------------------------------------------------------------------+
module bky_chain_loader
  import bky_pkg::*;
#(
  parameter int NBITS    = BKY_NBITS,
  parameter int HALF_PER = BKY_HALF_PER
) (
  input  logic                     clk,
  input  logic                     rst,
  bky_chain_loader_if.slave        bus
);

  localparam int c_HW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam int c_BW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [c_HW-1:0] c_HALF_LAST = c_HW'(HALF_PER - 1);
  localparam logic [c_BW-1:0] c_BIT_TOP   = c_BW'(NBITS - 1);

  bky_state_t          r_state;
  logic [c_HW-1:0]     r_half;
  logic [c_BW-1:0]     r_bit;
  logic [BKY_NCHIP:1]  r_mask;
  logic [NBITS-1:0]    r_pattern;
  logic                r_busy;
  logic                r_done;
  logic [BKY_NCHIP:1]  r_dsnd;
  logic [BKY_NCHIP:1]  r_bclk;
`ifdef BKY_VERIFY_EN
  logic                r_pass;
  logic [BKY_NCHIP:1]  r_mismatch;
`endif

  logic w_half_end;
  logic w_capture;
  logic w_last_pass;

  assign w_half_end = (r_half == c_HALF_LAST);
  // DRTN is sampled on the final HIGH cycle, before the chip sees BCLK fall.
  assign w_capture  = (r_state == HIGH) && w_half_end;

`ifdef BKY_VERIFY_EN
  assign w_last_pass = r_pass;
`else
  assign w_last_pass = 1'b1;
`endif

  // Pin outputs are derived from the current state, so they trail it by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_half     <= '0;
      r_bit      <= '0;
      r_mask     <= '0;
      r_pattern  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dsnd     <= '0;
      r_bclk     <= '0;
`ifdef BKY_VERIFY_EN
      r_pass     <= 1'b0;
      r_mismatch <= '0;
`endif
    end else begin
      r_busy <= (r_state != IDLE);
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          r_bclk <= '0;
          r_dsnd <= '0;
          // r_busy still covers the DONE pulse cycle, which blocks a restart there.
          if (bus.start && !r_busy) begin
            r_mask    <= bky_eff_mask(bus.mask);
            r_pattern <= bus.pattern;
            r_bit     <= c_BIT_TOP;
            r_half    <= '0;
`ifdef BKY_VERIFY_EN
            r_pass     <= 1'b0;
            r_mismatch <= '0;
`endif
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          r_bclk <= '0;
          r_dsnd <= r_mask & {BKY_NCHIP{r_pattern[r_bit]}};
          if (w_half_end) begin
            r_half  <= '0;
            r_state <= HIGH;
          end else begin
            r_half <= r_half + 1'b1;
          end
        end
        HIGH: begin
          r_bclk <= r_mask;
          if (w_half_end) begin
            r_half <= '0;
`ifdef BKY_VERIFY_EN
            if (r_pass) begin
              r_mismatch <= r_mismatch
                          | (r_mask & (bus.drtn ^ {BKY_NCHIP{r_pattern[r_bit]}}));
            end
`endif
            if (r_bit != '0) begin
              r_bit   <= r_bit - 1'b1;
              r_state <= SETUP;
            end else if (w_last_pass) begin
              r_state <= DONE;
            end else begin
`ifdef BKY_VERIFY_EN
              r_pass <= 1'b1;
`endif
              r_bit   <= c_BIT_TOP;
              r_state <= SETUP;
            end
          end else begin
            r_half <= r_half + 1'b1;
          end
        end
        DONE: begin
          r_bclk  <= '0;
          r_dsnd  <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  logic [NBITS-1:0] w_rb [1:BKY_NCHIP];

  for (genvar gi = 1; gi <= BKY_NCHIP; gi++) begin : g_rb
    bky_rb_shreg #(
      .NBITS (NBITS)
    ) u_shreg (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_capture & r_mask[gi]),
      .i_din (bus.drtn[gi]),
      .o_q   (w_rb[gi])
    );
  end

  logic [NBITS-1:0] w_rd_data;

  always_comb begin
    w_rd_data = '0;
    for (int i = 1; i <= BKY_NCHIP; i++) begin
      if (bus.rd_sel == 3'(i)) begin
        w_rd_data = w_rb[i];
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.dsnd    = r_dsnd;
  assign bus.bclk    = r_bclk;
  assign bus.rd_data = w_rd_data;
`ifdef BKY_VERIFY_EN
  assign bus.mismatch = r_mismatch;
`else
  assign bus.mismatch = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bky_chain_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bky_chain_loader : directed bench with Buckeye chip models and an     |
// |                       expected-result queue.                 Rev 1.0     |
// +--------------------------------------------------------------------------+
module tb_bky_chain_loader;
  import bky_pkg::*;

  localparam int N = BKY_NBITS;
`ifdef BKY_VERIFY_EN
  localparam int c_PASSES = 2;
`else
  localparam int c_PASSES = 1;
`endif
  localparam int c_LAT4 = 2 * 4 * N * c_PASSES + 1;
  localparam int c_LAT1 = 2 * 1 * N * c_PASSES + 1;

  typedef struct packed {
    logic [6*N-1:0] rb;
    logic [6*N-1:0] chip;
    logic [6:1]     mism;
    logic [31:0]    lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bky_chain_loader_if #(.NBITS(N)) bus  ();
  bky_chain_loader_if #(.NBITS(N)) bus1 ();

  bky_chain_loader #(.NBITS(N), .HALF_PER(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bky_chain_loader #(.NBITS(N), .HALF_PER(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Chip model: shifts DSND in on BCLK rise, presents its MSB on DRTN after BCLK falls.
  logic [N-1:0] chip        [1:6];
  logic [N-1:0] preload_val [1:6];
  logic         preload = 1'b0;
  logic         kill5   = 1'b0;
  logic [6:1]   drtn_raw;

  for (genvar gi = 1; gi <= 6; gi++) begin : g_chip
    logic [N-1:0] sreg;
    logic         dout;
    always @(posedge bus.bclk[gi] or posedge preload) begin
      if (preload) sreg <= preload_val[gi];
      else         sreg <= {sreg[N-2:0], bus.dsnd[gi]};
    end
    always @(negedge bus.bclk[gi] or posedge preload) begin
      if (preload) dout <= preload_val[gi][N-1];
      else         dout <= sreg[N-1];
    end
    assign chip[gi]     = sreg;
    assign drtn_raw[gi] = dout;
  end

  assign bus.drtn  = drtn_raw & ~{1'b0, kill5, 4'b0};
  assign bus1.drtn = '0;

  int           vectors = 0;
  int           fails   = 0;
  logic [N-1:0] rb_model [1:6];
  exp_t         sb [$];

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [6:1] msk, input logic [N-1:0] pat,
                         input int restart_at, input bit start_on_done, input int kill_at);
    exp_t         e;
    logic [6:1]   eff, stray, prev;
    logic [N-1:0] one;
    int           t0, lat, done_cnt, busy_gap, post, late_busy;
    int           rises [1:6];
    one = 1;
    eff = (msk == 6'd0) ? 6'b111111 : msk;
    e.mism = '0;
    e.lat  = c_LAT4;
    for (int i = 1; i <= 6; i++) begin
      e.rb[(i-1)*N +: N]   = !eff[i] ? rb_model[i] : ((c_PASSES == 2) ? pat : chip[i]);
      e.chip[(i-1)*N +: N] = eff[i] ? pat : chip[i];
      rises[i] = 0;
    end
    if (kill_at != 0) begin
      // The killed window spans exactly one second-pass capture (bit 33).
      e.mism         = 6'b010000;
      e.rb[4*N +: N] = pat & ~(one << 33);
    end
    sb.push_back(e);

    @(negedge clk);
    bus.mask = msk; bus.pattern = pat; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    t0 = cyc;
    lat = 0; done_cnt = 0; busy_gap = 0; post = 0; late_busy = 0;
    stray = '0; prev = bus.bclk;
    for (int k = 1; k <= c_LAT4 + 12; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == restart_at) begin
        bus.start = 1'b1; bus.mask = 6'b000001; bus.pattern = ~pat;
      end
      if (k == kill_at)     kill5 = 1'b1;
      if (k == kill_at + 8) kill5 = 1'b0;
      for (int i = 1; i <= 6; i++) if (bus.bclk[i] && !prev[i]) rises[i]++;
      prev   = bus.bclk;
      stray |= (bus.bclk | bus.dsnd) & ~eff;
      if (lat != 0) begin
        post++;
        if (bus.busy) late_busy++;
      end else if (!bus.busy) begin
        busy_gap++;
      end
      if (bus.done) begin
        done_cnt++;
        if (lat == 0) begin
          lat = cyc - t0;
          bus.start = start_on_done;
        end
      end
    end

    e = sb.pop_front();
    check("latency", N'(lat), N'(e.lat));
    check("done_pulses", N'(done_cnt), N'(1));
    check("busy_gaps", N'(busy_gap), '0);
    check("busy_after_done", N'(late_busy), '0);
    check("stray_unselected", N'(stray), '0);
    check("mismatch", N'(bus.mismatch), N'(e.mism));
    for (int i = 1; i <= 6; i++) begin
      check($sformatf("bclk_rises[%0d]", i), N'(rises[i]), eff[i] ? N'(N * c_PASSES) : '0);
      check($sformatf("chip[%0d]", i), chip[i], e.chip[(i-1)*N +: N]);
      bus.rd_sel = 3'(i);
      #1;
      check($sformatf("rd_data[%0d]", i), bus.rd_data, e.rb[(i-1)*N +: N]);
      rb_model[i] = e.rb[(i-1)*N +: N];
    end
  endtask

  task automatic do_abort();
    logic done_seen;
    @(negedge clk);
    bus.mask = '0; bus.pattern = 48'h1234_5678_9ABC; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (200) @(negedge clk);
    check("bclk_before_abort", N'(bus.bclk), N'(6'h3f));
    #1 rst = 1'b1;
    #1;
    check("bclk_abort", N'(bus.bclk), '0);
    check("dsnd_abort", N'(bus.dsnd), '0);
    check("busy_abort", N'(bus.busy), '0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      bus.rd_sel = 3'(i);
      #1;
      check($sformatf("rd_data_abort[%0d]", i), bus.rd_data, '0);
      rb_model[i] = '0;
    end
    done_seen = 1'b0;
    repeat (c_LAT4) begin
      @(negedge clk);
      done_seen |= bus.done;
    end
    check("done_after_abort", N'(done_seen), '0);
  endtask

  task automatic do_fast();
    int   t0, lat, highs, rises;
    logic prev;
    @(negedge clk);
    bus1.mask = '0; bus1.pattern = 48'h5A5A_C3C3_0FF0; bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    t0 = cyc; lat = 0; highs = 0; rises = 0; prev = bus1.bclk[1];
    for (int k = 1; k <= c_LAT1 + 10; k++) begin
      @(negedge clk);
      if (bus1.bclk[1]) highs++;
      if (bus1.bclk[1] && !prev) rises++;
      prev = bus1.bclk[1];
      if (bus1.done && lat == 0) lat = cyc - t0;
    end
    check("fast_latency", N'(lat), N'(c_LAT1));
    check("fast_rises", N'(rises), N'(N * c_PASSES));
    check("fast_high_cycles", N'(highs), N'(N * c_PASSES));
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.mask = '0; bus.pattern = '0; bus.rd_sel = 3'd1;
    bus1.start = 1'b0; bus1.mask = '0; bus1.pattern = '0; bus1.rd_sel = 3'd1;
    for (int i = 1; i <= 6; i++) begin
      preload_val[i] = 48'h1;
      rb_model[i]    = '0;
    end
    #1 preload = 1'b1;
    #1 preload = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", N'(bus.busy), '0);
    check("reset_done", N'(bus.done), '0);
    check("reset_bclk", N'(bus.bclk), '0);
    check("reset_dsnd", N'(bus.dsnd), '0);
    check("reset_mismatch", N'(bus.mismatch), '0);
    check("reset_rd_data", bus.rd_data, '0);
    rst = 1'b0;

    do_load(6'b000000, 48'hA5A5_0F0F_3C3C, 0, 1'b1, 0);
    bus.rd_sel = 3'd0;
    #1 check("rd_sel_0", bus.rd_data, '0);
    bus.rd_sel = 3'd7;
    #1 check("rd_sel_7", bus.rd_data, '0);

    do_load(6'b000100, 48'hFFFF_FFFF_FFFF, 0, 1'b0, 0);
    do_load(6'b000000, 48'h0123_4567_89AB, 100, 1'b0, 0);
    do_abort();
    do_load(6'b101010, 48'hDEAD_BEEF_CAFE, 0, 1'b0, 0);
    do_fast();
`ifdef BKY_VERIFY_EN
    do_load(6'b000000, 48'hFFFF_FFFF_FFFF, 0, 1'b0, 500);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
